whack_game_ctrl: RTL
====================

# whack_game_ctrl

Top-level game sequencer for the whack-a-mole design. It owns the round flow: idle, get-ready, play and game-over. While a round runs it drives the 30-second countdown timer's `reset`, watches its `count` output, and picks the lit mole hole with an LFSR. It also scores player hits and keeps a high score.

## Interface

Parameters:
- `NUM_HOLES`, default 4: number of holes; power of two, 2..8.
- `MOLE_CYCLES`, default 25_000_000: clk cycles each mole slot lasts.
- `READY_CYCLES`, default 100_000_000: clk cycles spent in READY. Must be at least two timer-clock periods so the timer reloads to 30.

Ports:
- `clk`  in  1: system clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-high. Clears everything, including the high score.
- `start`  in  1: single-cycle pulse, debounced upstream.
- `hit`  in  NUM_HOLES: per-hole button pulses, debounced upstream.
- `time_left`  in  5: timer countdown value, 30..0.
- `timer_reset`  out  1: drives the timer's `reset`.
- `mole`  out  NUM_HOLES: one-hot lit hole, or all-zero.
- `score`  out  8: current round score.
- `high_score`  out  8: best score since reset.
- `state`  out  2: IDLE=0, READY=1, PLAY=2, OVER=3.
- `game_over`  out  1: high while in OVER.

## Operation

Reset values (one cycle after `reset` sampled high):
- `state`=IDLE, `timer_reset`=1, `mole`=0, `score`=0, `high_score`=0, `game_over`=0.
- LFSR=8'hA5, slot counter=0, `armed`=0.

State transitions:
- IDLE → READY on `start`.
- READY: `timer_reset`=1, `score` cleared on entry, `armed` cleared. After exactly READY_CYCLES cycles in READY → PLAY.
- PLAY: `timer_reset`=0.
  - `armed` is set on the first cycle with `time_left`==30.
  - PLAY → OVER when `armed`=1 and `time_left`==0. A stale 0 before the reload is ignored.
- OVER: `game_over`=1, `mole`=0, `timer_reset`=1. OVER → READY on `start`.
- `start` is ignored in READY and PLAY.
- `reset` mid-round returns everything to the reset values on the next cycle.

LFSR:
- 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
- Shifts every clk cycle in every state, so round timing seeds randomness.

Mole selection (at each slot load):
- idx = LFSR[log2(NUM_HOLES)-1:0].
- If idx equals the previous slot's hole, use idx+1 mod NUM_HOLES.
- `mole` = one-hot(idx). The slot counter restarts at 0.
- First load happens on the READY→PLAY transition, so `mole` is valid on the first PLAY cycle.
- A new load occurs when the slot counter reaches MOLE_CYCLES-1.

Scoring (PLAY only, evaluated each cycle):
- Hit: (`hit` & `mole`) ≠ 0.
  - `score`+1, saturating at 255.
  - `mole` → 0 for the rest of the slot.
- Miss: `hit` ≠ 0 and not a hit (includes `hit` while `mole`==0).
  - `score`−1, saturating at 0.
- Several `hit` bits in one cycle count as one event. Hit takes precedence over miss.
- Hit on a slot-expiry cycle: the score counts and the new mole still loads that cycle; the load overrides the clear.
- `hit` outside PLAY is ignored.

High score:
- On the PLAY→OVER transition cycle, evaluate `score` including any hit that same cycle.
- If that value > `high_score`, copy it. Ties leave it unchanged.

## Timing

- All outputs are registered.
- `state`/`timer_reset` change on the cycle after the causing input is sampled.
- `score` updates one cycle after the `hit` sample.
- `mole` clears one cycle after a hit.
- `game_over` and `high_score` update one cycle after `time_left`==0 is sampled with `armed`=1.
- READY lasts exactly READY_CYCLES cycles.
- Each mole slot lasts exactly MOLE_CYCLES cycles.

## Test plan

Simulation parameters for all scenarios: MOLE_CYCLES=8, READY_CYCLES=4, NUM_HOLES=4; the bench models the timer.

- **Reset:** assert `reset` 2 cycles → `state`=0, `timer_reset`=1, `mole`=0, `score`=0, `high_score`=0.
- **Round start:** `start` pulse in IDLE → `state`=1 for exactly 4 cycles, then `state`=2, `timer_reset`=0, `mole` one-hot. `mole` changes every 8 cycles and never repeats the same hole twice in a row.
- **Hit and miss:**
  - Matching `hit` → `score` 0→1 and `mole`=0 next cycle.
  - Non-matching `hit` → `score` 1→0.
  - A further miss → `score` stays 0.
  - 256 hits → `score` holds 255.
- **Stale timer:** `time_left`=0 for the first 3 PLAY cycles, then 30 → stays in PLAY. A later `time_left`=0 → `state`=3, `game_over`=1, `high_score`=`score`.
- **High score:**
  - Second round with a lower score → `high_score` unchanged.
  - Equal score → unchanged.
  - Higher score → updated.
  - `start` during PLAY → no effect.
- **Reset mid-play:** `reset` with `score`=5 in PLAY → all reset values next cycle, `high_score`=0.

Source files
------------

// File: rtl/whack_game_ctrl.sv
// Round sequencer for whack-a-mole: IDLE/READY/PLAY/OVER flow, LFSR mole picker,
// saturating hit/miss scoring and a high score kept across rounds until reset.
module whack_game_ctrl #(
  parameter int NUM_HOLES    = 4,
  parameter int MOLE_CYCLES  = 25_000_000,
  parameter int READY_CYCLES = 100_000_000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [NUM_HOLES-1:0] hit_i,
  input  logic [4:0]           time_left_i,
  output logic                 timer_reset_o,
  output logic [NUM_HOLES-1:0] mole_o,
  output logic [7:0]           score_o,
  output logic [7:0]           high_score_o,
  output logic [1:0]           state_o,
  output logic                 game_over_o
);

  localparam int IDX_W  = $clog2(NUM_HOLES);
  localparam int SLOT_W = $clog2(MOLE_CYCLES + 1);
  localparam int RDY_W  = $clog2(READY_CYCLES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MOLE_CYCLES - 1);
  localparam logic [RDY_W-1:0]  RDY_LAST  = RDY_W'(READY_CYCLES - 1);

  // state_o exposes the FSM encoding directly for checkers and the display.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e               state_q;
  logic [7:0]           lfsr_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [RDY_W-1:0]     rdy_q;
  logic                 armed_q;
  logic [IDX_W-1:0]     prev_idx_q;
  logic [NUM_HOLES-1:0] mole_q;
  logic [7:0]           score_q;
  logic [7:0]           high_q;
  logic                 timer_reset_q;
  logic                 game_over_q;

  logic                 lfsr_fb;
  logic [IDX_W-1:0]     raw_idx;
  logic [IDX_W-1:0]     new_idx;
  logic [NUM_HOLES-1:0] new_mole;
  logic                 is_hit;
  logic                 is_miss;
  logic [7:0]           score_nxt;

  always_comb begin
    lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    raw_idx  = lfsr_q[IDX_W-1:0];
    // Never light the same hole twice in a row.
    new_idx  = (raw_idx == prev_idx_q) ? raw_idx + IDX_W'(1) : raw_idx;
    new_mole = '0;
    new_mole[new_idx] = 1'b1;
    is_hit    = |(hit_i & mole_q);
    is_miss   = (|hit_i) && !is_hit;
    score_nxt = score_q;
    if (is_hit && score_q != 8'hFF) begin
      score_nxt = score_q + 8'd1;
    end else if (is_miss && score_q != 8'h00) begin
      score_nxt = score_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 8'hA5;
      slot_q        <= '0;
      rdy_q         <= '0;
      armed_q       <= 1'b0;
      prev_idx_q    <= '0;
      mole_q        <= '0;
      score_q       <= 8'd0;
      high_q        <= 8'd0;
      timer_reset_q <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q       <= S_READY;
            rdy_q         <= '0;
            score_q       <= 8'd0;
            armed_q       <= 1'b0;
            timer_reset_q <= 1'b1;
          end
        end
        S_READY: begin
          if (rdy_q == RDY_LAST) begin
            state_q       <= S_PLAY;
            timer_reset_q <= 1'b0;
            mole_q        <= new_mole;
            prev_idx_q    <= new_idx;
            slot_q        <= '0;
          end else begin
            rdy_q <= rdy_q + RDY_W'(1);
          end
        end
        S_PLAY: begin
          score_q <= score_nxt;
          if (time_left_i == 5'd30) armed_q <= 1'b1;
          // A zero seen before the timer has reloaded to 30 is stale.
          if (armed_q && time_left_i == 5'd0) begin
            state_q       <= S_OVER;
            mole_q        <= '0;
            timer_reset_q <= 1'b1;
            game_over_q   <= 1'b1;
            if (score_nxt > high_q) high_q <= score_nxt;
          end else if (slot_q == SLOT_LAST) begin
            mole_q     <= new_mole;
            prev_idx_q <= new_idx;
            slot_q     <= '0;
          end else begin
            slot_q <= slot_q + SLOT_W'(1);
            if (is_hit) mole_q <= '0;
          end
        end
        S_OVER: begin
          if (start_i) begin
            state_q     <= S_READY;
            rdy_q       <= '0;
            score_q     <= 8'd0;
            armed_q     <= 1'b0;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign timer_reset_o = timer_reset_q;
  assign mole_o        = mole_q;
  assign score_o       = score_q;
  assign high_score_o  = high_q;
  assign state_o       = state_q;
  assign game_over_o   = game_over_q;

endmodule
